// File: rtl/noc_link_isolator_pkg.sv
// Shared types and helpers for the NoC link isolator: FSM state encoding,
// flit framing bit positions and the VC index width rule.
package noc_link_isolator_pkg;

  typedef enum logic [1:0] {
    ISO_ACTIVE   = 2'd0,
    ISO_DRAINING = 2'd1,
    ISO_ISOLATED = 2'd2
  } noc_iso_state_e;

  // Framing bits sit at the top of the flit: head is the MSB, tail just below.
  function automatic int flit_head_bit(input int flit_width);
    return flit_width - 1;
  endfunction

  function automatic int flit_tail_bit(input int flit_width);
    return flit_width - 2;
  endfunction

  // VC index width, never narrower than one bit even for a single VC.
  function automatic int vc_width(input int num_vc);
    return (num_vc > 1) ? $clog2(num_vc) : 1;
  endfunction

endpackage

// File: rtl/noc_link_isolator_if.sv
// Upstream and downstream flit channels of one directional link.
interface noc_link_isolator_if
  import noc_link_isolator_pkg::*;
#(
  parameter int NUM_VC     = 2,
  parameter int FLIT_WIDTH = 64
);
  localparam int VC_W = vc_width(NUM_VC);

  // Handshake: a flit moves upstream when up_valid && up_ready[up_vc] at a rising
  // edge, and downstream when down_valid && down_ready; a presented flit stays
  // stable until taken, and ready never depends on valid.
  logic                  up_valid;
  logic [VC_W-1:0]       up_vc;
  logic [FLIT_WIDTH-1:0] up_flit;
  logic [NUM_VC-1:0]     up_ready;

  logic                  down_valid;
  logic [VC_W-1:0]       down_vc;
  logic [FLIT_WIDTH-1:0] down_flit;
  logic                  down_ready;

  modport master (
    output up_valid, up_vc, up_flit, down_ready,
    input  up_ready, down_valid, down_vc, down_flit
  );

  modport slave (
    input  up_valid, up_vc, up_flit, down_ready,
    output up_ready, down_valid, down_vc, down_flit
  );

endinterface

// File: rtl/noc_link_fifo.sv
// Two-entry FIFO; a full FIFO refuses a push even when a pop happens that cycle.
module noc_link_fifo #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic          push;
  logic          pop;

  assign full      = (count == 2'd2);
  assign empty     = (count == 2'd0);
  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && !full;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/noc_link_isolator.sv
// Runtime gate on one inter-router link: buffers flits, tracks open packets per VC,
// and on request drains to a packet boundary before fencing the link.
module noc_link_isolator
  import noc_link_isolator_pkg::*;
#(
  parameter int NUM_VC        = 2,
  parameter int FLIT_WIDTH    = 64,
  parameter int DRAIN_TIMEOUT = 255
) (
  input  logic                noc_clk,
  input  logic                noc_rst_n,
  noc_link_isolator_if.slave  link,
  input  logic                isolate_req,
  output logic                iso_ack,
  output logic                drain_timeout,
  output logic                proto_err,
  output logic [NUM_VC-1:0]   open_vc,
  output noc_iso_state_e      dbg_state
);

  localparam int VC_W          = vc_width(NUM_VC);
  localparam int FLIT_HEAD_BIT = flit_head_bit(FLIT_WIDTH);
  localparam int FLIT_TAIL_BIT = flit_tail_bit(FLIT_WIDTH);
  localparam int CNT_W         = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(DRAIN_TIMEOUT);

  noc_iso_state_e            state;
  logic [CNT_W-1:0]          drain_cnt;
  logic [CNT_W-1:0]          cnt_nxt;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      fifo_out_valid;
  logic [VC_W+FLIT_WIDTH-1:0] fifo_out_data;
  logic [NUM_VC-1:0]         up_ready_int;
  logic                      vc_ok;
  logic                      accept;
  logic                      head;
  logic                      tail;

  always_comb begin
    up_ready_int = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      up_ready_int[v] = !fifo_full &&
                        ((state == ISO_ACTIVE) || ((state == ISO_DRAINING) && open_vc[v]));
    end
  end

  assign link.up_ready = up_ready_int;
  assign vc_ok         = (int'(link.up_vc) < NUM_VC);
  assign accept        = link.up_valid && vc_ok && up_ready_int[link.up_vc];
  assign head          = link.up_flit[FLIT_HEAD_BIT];
  assign tail          = link.up_flit[FLIT_TAIL_BIT];
  assign cnt_nxt       = (drain_cnt == TO_VAL) ? drain_cnt : drain_cnt + 1'b1;
  assign dbg_state     = state;

  noc_link_fifo #(.DW(VC_W + FLIT_WIDTH)) u_fifo (
    .clk       (noc_clk),
    .rst_n     (noc_rst_n),
    .in_valid  (accept),
    .in_data   ({link.up_vc, link.up_flit}),
    .out_valid (fifo_out_valid),
    .out_data  (fifo_out_data),
    .out_ready (link.down_ready && (state != ISO_ISOLATED)),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // The fence also zeroes the data lines so nothing stale leaks while isolated.
  assign link.down_valid = fifo_out_valid && (state != ISO_ISOLATED);
  assign link.down_vc    = link.down_valid ? fifo_out_data[VC_W+FLIT_WIDTH-1:FLIT_WIDTH] : '0;
  assign link.down_flit  = link.down_valid ? fifo_out_data[FLIT_WIDTH-1:0] : '0;

  always_ff @(posedge noc_clk) begin
    if (!noc_rst_n) begin
      state         <= ISO_ACTIVE;
      iso_ack       <= 1'b0;
      drain_cnt     <= '0;
      drain_timeout <= 1'b0;
      proto_err     <= 1'b0;
      open_vc       <= '0;
    end else begin
      // A head on an open VC and a non-head on a closed VC are both framing errors.
      proto_err <= accept && (head == open_vc[link.up_vc]);
      if (accept) begin
        if (tail)      open_vc[link.up_vc] <= 1'b0;
        else if (head) open_vc[link.up_vc] <= 1'b1;
      end

      case (state)
        ISO_ACTIVE: begin
          if (isolate_req) begin
            state     <= ISO_DRAINING;
            drain_cnt <= '0;
          end
        end
        ISO_DRAINING: begin
          if (!isolate_req) begin
            state         <= ISO_ACTIVE;
            drain_timeout <= 1'b0;
          end else begin
            drain_cnt <= cnt_nxt;
            if (cnt_nxt == TO_VAL) drain_timeout <= 1'b1;
            // An accept this cycle may still be a tail, so wait one more cycle.
            if ((open_vc == '0) && fifo_empty && !accept) begin
              state   <= ISO_ISOLATED;
              iso_ack <= 1'b1;
            end
          end
        end
        ISO_ISOLATED: begin
          if (!isolate_req) begin
            state         <= ISO_ACTIVE;
            iso_ack       <= 1'b0;
            drain_timeout <= 1'b0;
          end
        end
        default: begin
          state   <= ISO_ACTIVE;
          iso_ack <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/noc_link_isolator.md
Name: noc_link_isolator

Overview:
- Runtime-controllable gate on one directional inter-router link.
- Successor to the fabric's static tie-off of inactive nodes and edge ports.
- Instantiated per link, between a node's position mux and the neighbouring router.
- Buffers flits in a 2-entry FIFO and tracks open packets per VC.
- On request, drains to a packet boundary and then fences the link, so a node can be power- or fault-isolated and later resumed without cutting a packet.

Parameters:
NUM_VC, 2, number of virtual channels (>=1)
FLIT_WIDTH, 64, flit width in bits; bit FLIT_WIDTH-1 = head, bit FLIT_WIDTH-2 = tail
DRAIN_TIMEOUT, 255, drain cycles before drain_timeout asserts (>=1)

Ports:
noc_clk  in  1  clock
noc_rst_n  in  1  synchronous active-low reset
up_valid  in  1  upstream flit valid
up_vc  in  $clog2(NUM_VC) (min 1)  VC of upstream flit
up_flit  in  FLIT_WIDTH  upstream flit
up_ready  out  NUM_VC  per-VC accept; transfer occurs when up_valid && up_ready[up_vc]
down_valid  out  1  downstream flit valid
down_vc  out  $clog2(NUM_VC) (min 1)  VC of downstream flit
down_flit  out  FLIT_WIDTH  downstream flit
down_ready  in  1  downstream accept
isolate_req  in  1  level request to isolate the link
iso_ack  out  1  high while the link is fenced (state ISOLATED)
drain_timeout  out  1  drain exceeded DRAIN_TIMEOUT
proto_err  out  1  one-cycle pulse on a head/tail framing violation
open_vc  out  NUM_VC  per-VC open-packet bitmap

Behaviour:
- Reset (sync, noc_rst_n=0 at posedge):
  - State ACTIVE; FIFO empty; open_vc=0; timeout counter=0.
  - down_valid=0, iso_ack=0, drain_timeout=0, proto_err=0.
  - up_ready=all-ones the cycle after reset release.
  - Reset during DRAINING or ISOLATED discards buffered flits.
- FIFO: 2 entries holding {vc, flit}.
  - up_ready[v] = !full && (state==ACTIVE || (state==DRAINING && open_vc[v])).
  - In ISOLATED, up_ready=0.
  - No pop-through: when full, up_ready=0 even if down_ready=1.
  - Latency: a flit accepted at edge N is presented at down_* after edge N (1 cycle); back-to-back throughput 1 flit/cycle.
  - down_valid = !empty.
  - down_* stay stable while down_valid && !down_ready.
- Open tracking, on each accepted flit on VC v:
  - Head without tail: sets open_vc[v].
  - Tail: clears open_vc[v].
  - Head+tail (single-flit packet): leaves open_vc[v]=0.
  - Body: no change.
- proto_err pulses 1 cycle, registered, in either case:
  - A head arrives on VC v while open_vc[v]=1.
  - A non-head flit arrives on VC v while open_vc[v]=0.
  - The flit is still forwarded and open_vc updated per its bits.
- FSM {ACTIVE, DRAINING, ISOLATED}:
  - ACTIVE & isolate_req -> DRAINING.
  - DRAINING & !isolate_req -> ACTIVE (abort).
  - DRAINING & open_vc==0 & FIFO empty & no accept this cycle -> ISOLATED.
  - ISOLATED & !isolate_req -> ACTIVE.
  - iso_ack = (state==ISOLATED), registered.
  - The ISOLATED fence is up_ready=0, down_valid=0, down_flit=0, down_vc=0.
- Timeout:
  - Counter clears on entering DRAINING and increments each DRAINING cycle, saturating at DRAIN_TIMEOUT.
  - drain_timeout=1 when counter==DRAIN_TIMEOUT; held until the next entry to ACTIVE.
  - A timeout does not force ISOLATED.
- Simultaneous events:
  - Push and pop in the same cycle keep the FIFO count.
  - A tail accept in the cycle the drain condition is otherwise met delays ISOLATED by 1 cycle.

Decomposition:
- Noc_parameters: FLIT_HEAD_BIT and FLIT_TAIL_BIT localparams, and the typedef enum logic [1:0] noc_iso_state_e {ISO_ACTIVE, ISO_DRAINING, ISO_ISOLATED}.
- Sub-module noc_link_fifo:
  - 2-entry valid/ready FIFO parametrised on data width.
  - Outputs full and empty.

Test Plan:
- Reset then one single-flit packet on VC1 (head+tail) -> appears on down_* exactly 1 cycle after accept; open_vc stays 0; proto_err stays 0.
- 4-flit packet on VC0 with down_ready=0 -> FIFO fills after 2 accepts, up_ready=2'b00; data held stable. Release down_ready -> flits drain in order; open_vc[0] 1 after head, 0 after tail.
- VC0 mid-packet, isolate_req=1 -> up_ready=2'b01 (VC1 heads blocked). After tail accepted and FIFO emptied, iso_ack=1 and up_ready=0; drop isolate_req -> ACTIVE next cycle, iso_ack=0.
- DRAIN_TIMEOUT=4, VC0 open, tail withheld -> drain_timeout=1 on the 5th DRAINING cycle and held; then send tail -> ISOLATED; deassert isolate_req -> drain_timeout=0.
- Head on VC0 while open_vc[0]=1, and body on closed VC1 -> proto_err pulses 1 cycle for each; both flits forwarded.
- Reset asserted while ISOLATED with data previously buffered -> next cycle state ACTIVE, down_valid=0, open_vc=0, up_ready=all-ones.
